multu_hilo_unit: RTL

Sequential 32x32 unsigned multiplier with the HI/LO register pair, sitting downstream of the ALU control block in the single-cycle MIPS datapath. It is the execution end of the MULTU / MFHI / MFLO handshake. It takes the 6-bit function code and the `mulRes` start level from the control block and runs a 32-step shift-add multiply. It commits the 64-bit product into HI/LO on the control block's commit code (6'b111111) and drives HI or LO onto its result port for MFHI/MFLO.

---
 rtl/multu_hilo_unit_if.sv | 24 ++
 rtl/multu_hilo_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/multu_hilo_unit_if.sv
// Control-block <-> multiply unit bundle: operands, function code, start level,
// and the unit's result/status outputs.
interface multu_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [5:0]       Signal;
  logic             mulRes;
  logic [WIDTH-1:0] dataOut;
  logic             busy;
  logic             done;
  logic             seqErr;

  modport master (
    output dataA, dataB, Signal, mulRes,
    input  dataOut, busy, done, seqErr
  );

  modport slave (
    input  dataA, dataB, Signal, mulRes,
    output dataOut, busy, done, seqErr
  );
endinterface

// File: rtl/multu_hilo_unit.sv
// Sequential WIDTHxWIDTH unsigned shift-add multiplier feeding the HI/LO pair.
// Define MULTU_SEQ_CHECK_EN to build the sticky seqErr sequencing checker.
module multu_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  multu_hilo_unit_if.slave bus
);
  localparam int STEP_W = $clog2(WIDTH) + 1;
  localparam logic [5:0] FN_MULTU  = 6'b011001;
  localparam logic [5:0] FN_MFHI   = 6'b010000;
  localparam logic [5:0] FN_MFLO   = 6'b010010;
  localparam logic [5:0] FN_COMMIT = 6'b111111;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d, prod_sum;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic                 pend_q, pend_d;
  logic                 done_q, done_d;
  logic                 mulres_q;
  logic                 start, commit, finish, idle_commit;

  // Only the rising edge of mulRes starts a multiply; a held level does not retrigger.
  assign start       = bus.mulRes && !mulres_q && (bus.Signal == FN_MULTU);
  assign commit      = (bus.Signal == FN_COMMIT);
  assign finish      = (state_q == RUN) && !start && (step_q == LAST_STEP);
  assign idle_commit = (state_q == IDLE) && commit;
  assign prod_sum    = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path can infer a latch.
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    step_d   = step_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    pend_d   = pend_q;
    done_d   = 1'b0;

    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, bus.dataA};
      mplier_d = bus.dataB;
      prod_d   = '0;
      step_d   = '0;
      pend_d   = 1'b0;
      state_d  = RUN;
    end else if (state_q == RUN) begin
      prod_d   = prod_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      step_d   = step_q + 1'b1;
      if (commit) pend_d = 1'b1;
      if (finish) begin
        done_d  = 1'b1;
        pend_d  = 1'b0;
        state_d = IDLE;
        // A commit seen during the run lands with the finished product.
        if (pend_q || commit) begin
          hi_d = prod_sum[2*WIDTH-1:WIDTH];
          lo_d = prod_sum[WIDTH-1:0];
        end
      end
    end else if (idle_commit) begin
      hi_d = prod_q[2*WIDTH-1:WIDTH];
      lo_d = prod_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      step_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      mulres_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      step_q   <= step_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      mulres_q <= bus.mulRes;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;

  always_comb begin
    bus.dataOut = '0;
    if (bus.Signal == FN_MFHI)      bus.dataOut = hi_q;
    else if (bus.Signal == FN_MFLO) bus.dataOut = lo_q;
  end

`ifdef MULTU_SEQ_CHECK_EN
  logic avail_q, avail_d, err_q;

  // avail: a finished product exists that no commit has consumed yet.
  always_comb begin
    avail_d = avail_q;
    if (finish)           avail_d = !(pend_q || commit);
    else if (idle_commit) avail_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avail_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      avail_q <= avail_d;
      err_q   <= err_q | (start && (state_q == RUN)) | (idle_commit && !avail_q);
    end
  end

  assign bus.seqErr = err_q;
`else
  assign bus.seqErr = 1'b0;
`endif
endmodule
